// File: rtl/fighter_state_controller.sv
// Per-player frame-driven fighter state machine feeding the sprite renderer.
// Latency: outputs registered, update one clk after a frame_tick; no backpressure.
module fighter_state_controller #(
  parameter bit          IS_MIRRORED = 1'b0,
  parameter int unsigned ATK_START   = 4,
  parameter int unsigned ATK_ACTIVE  = 2,
  parameter int unsigned ATK_RECOV   = 8,
  parameter int unsigned DIR_START   = 5,
  parameter int unsigned DIR_ACTIVE  = 3,
  parameter int unsigned DIR_RECOV   = 10,
  parameter int unsigned HITSTUN     = 12,
  parameter int unsigned BLOCKSTUN   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       hit_in,
  output logic [3:0] state,
  output logic [4:0] phase_cnt,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_BACK       = 4'd1,
    S_FWD        = 4'd2,
    S_ATK_START  = 4'd3,
    S_ATK_ACTIVE = 4'd4,
    S_ATK_RECOV  = 4'd5,
    S_DIR_START  = 4'd6,
    S_DIR_ACTIVE = 4'd7,
    S_DIR_RECOV  = 4'd8,
    S_HITSTUN    = 4'd9,
    S_BLOCKSTUN  = 4'd10
  } state_e;

  localparam logic [4:0] LD_ATK_START  = 5'(ATK_START - 1);
  localparam logic [4:0] LD_ATK_ACTIVE = 5'(ATK_ACTIVE - 1);
  localparam logic [4:0] LD_ATK_RECOV  = 5'(ATK_RECOV - 1);
  localparam logic [4:0] LD_DIR_START  = 5'(DIR_START - 1);
  localparam logic [4:0] LD_DIR_ACTIVE = 5'(DIR_ACTIVE - 1);
  localparam logic [4:0] LD_DIR_RECOV  = 5'(DIR_RECOV - 1);
  localparam logic [4:0] LD_HITSTUN    = 5'(HITSTUN - 1);
  localparam logic [4:0] LD_BLOCKSTUN  = 5'(BLOCKSTUN - 1);

  state_e     state_q, state_d;
  logic [4:0] phase_q, phase_d;
  logic       attack_active_q, attack_active_d;
  logic       busy_q, busy_d;
  logic       btn_attack_q;
  logic       atk_pend_q;
  logic       hit_pend_q;

  logic atk_rise;
  logic atk_evt;
  logic hit_evt;
  logic fwd;
  logic back;
  logic timed;

  // Events landing on the tick clk count as if already latched.
  assign atk_rise = btn_attack & ~btn_attack_q;
  assign atk_evt  = atk_pend_q | atk_rise;
  assign hit_evt  = hit_pend_q | hit_in;
  assign fwd      = IS_MIRRORED ? btn_left  : btn_right;
  assign back     = IS_MIRRORED ? btn_right : btn_left;
  assign timed    = (state_q >= S_ATK_START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_attack_q <= 1'b0;
      atk_pend_q   <= 1'b0;
      hit_pend_q   <= 1'b0;
    end else begin
      btn_attack_q <= btn_attack;
      if (frame_tick) begin
        atk_pend_q <= 1'b0;
        hit_pend_q <= 1'b0;
      end else begin
        if (atk_rise) atk_pend_q <= 1'b1;
        if (hit_in)   hit_pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (hit_evt && (state_q != S_HITSTUN) && (state_q != S_BLOCKSTUN)) begin
        if (state_q == S_BACK) begin
          state_d = S_BLOCKSTUN;
          phase_d = LD_BLOCKSTUN;
        end else begin
          state_d = S_HITSTUN;
          phase_d = LD_HITSTUN;
        end
      end else if (timed) begin
        if (phase_q != 5'd0) begin
          phase_d = phase_q - 5'd1;
        end else begin
          // Phase exhausted: chain to the next phase or drop back to idle.
          case (state_q)
            S_ATK_START: begin
              state_d = S_ATK_ACTIVE;
              phase_d = LD_ATK_ACTIVE;
            end
            S_ATK_ACTIVE: begin
              state_d = S_ATK_RECOV;
              phase_d = LD_ATK_RECOV;
            end
            S_DIR_START: begin
              state_d = S_DIR_ACTIVE;
              phase_d = LD_DIR_ACTIVE;
            end
            S_DIR_ACTIVE: begin
              state_d = S_DIR_RECOV;
              phase_d = LD_DIR_RECOV;
            end
            default: begin
              state_d = S_IDLE;
              phase_d = 5'd0;
            end
          endcase
        end
      end else if (atk_evt) begin
        if (fwd && !back) begin
          state_d = S_DIR_START;
          phase_d = LD_DIR_START;
        end else begin
          state_d = S_ATK_START;
          phase_d = LD_ATK_START;
        end
      end else begin
        phase_d = 5'd0;
        if (fwd && !back)      state_d = S_FWD;
        else if (back && !fwd) state_d = S_BACK;
        else                   state_d = S_IDLE;
      end
    end
    attack_active_d = (state_d == S_ATK_ACTIVE) || (state_d == S_DIR_ACTIVE);
    busy_d          = (state_d >= S_ATK_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      phase_q         <= 5'd0;
      attack_active_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      attack_active_q <= attack_active_d;
      busy_q          <= busy_d;
    end
  end

  assign state         = state_q;
  assign phase_cnt     = phase_q;
  assign attack_active = attack_active_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fighter_state_controller.sv
// Bench for fighter_state_controller: vector table, hand sequences, and random
// stimulus against a frame-schedule reference model (both facing directions).
module tb_fighter_state_controller;

  localparam int ATK_START = 4, ATK_ACTIVE = 2, ATK_RECOV = 8;
  localparam int DIR_START = 5, DIR_ACTIVE = 3, DIR_RECOV = 10;
  localparam int HITSTUN = 12, BLOCKSTUN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0, hit_in = 1'b0;
  logic [3:0] st0, st1;
  logic [4:0] ph0, ph1;
  logic aa0, aa1, bz0, bz1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fighter_state_controller #(.IS_MIRRORED(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .hit_in(hit_in),
    .state(st0), .phase_cnt(ph0), .attack_active(aa0), .busy(bz0));

  fighter_state_controller #(.IS_MIRRORED(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .hit_in(hit_in),
    .state(st1), .phase_cnt(ph1), .attack_active(aa1), .busy(bz1));

  // Reference model: each timed move is a list of per-frame states; a tick pops one.
  logic [3:0] cur [2];
  logic [3:0] sched [2][64];
  int s_len [2];
  int s_pos [2];
  bit prev_a, atk_p, hit_p;

  function automatic void push_run(int m, logic [3:0] s, int n);
    for (int i = 0; i < n; i++) begin
      sched[m][s_len[m]] = s;
      s_len[m]++;
    end
  endfunction

  function automatic void pop_frame(int m);
    cur[m] = sched[m][s_pos[m]];
    s_pos[m]++;
  endfunction

  function automatic int frames_left(int m);
    int c;
    bit run;
    c = 0;
    run = 1'b1;
    for (int i = s_pos[m]; i < s_len[m]; i++) begin
      if (run && sched[m][i] == cur[m]) c++;
      else run = 1'b0;
    end
    return c;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      cur[m] = 4'd0;
      s_len[m] = 0;
      s_pos[m] = 0;
    end
    prev_a = 1'b0;
    atk_p = 1'b0;
    hit_p = 1'b0;
  endfunction

  function automatic void step_one(int m, bit l, bit r, bit atk, bit hit);
    bit f, b;
    f = (m == 0) ? r : l;
    b = (m == 0) ? l : r;
    if (hit && cur[m] != 4'd9 && cur[m] != 4'd10) begin
      s_len[m] = 0;
      s_pos[m] = 0;
      if (cur[m] == 4'd1) push_run(m, 4'd10, BLOCKSTUN);
      else push_run(m, 4'd9, HITSTUN);
      push_run(m, 4'd0, 1);
      pop_frame(m);
    end else if (s_pos[m] < s_len[m]) begin
      pop_frame(m);
    end else if (atk) begin
      s_len[m] = 0;
      s_pos[m] = 0;
      if (f && !b) begin
        push_run(m, 4'd6, DIR_START);
        push_run(m, 4'd7, DIR_ACTIVE);
        push_run(m, 4'd8, DIR_RECOV);
      end else begin
        push_run(m, 4'd3, ATK_START);
        push_run(m, 4'd4, ATK_ACTIVE);
        push_run(m, 4'd5, ATK_RECOV);
      end
      push_run(m, 4'd0, 1);
      pop_frame(m);
    end else begin
      cur[m] = (f && !b) ? 4'd2 : ((b && !f) ? 4'd1 : 4'd0);
    end
  endfunction

  function automatic void model_step(bit tk, bit l, bit r, bit a, bit h);
    bit atk_ev, hit_ev;
    atk_ev = atk_p | (a & ~prev_a);
    hit_ev = hit_p | h;
    if (tk) begin
      step_one(0, l, r, atk_ev, hit_ev);
      step_one(1, l, r, atk_ev, hit_ev);
      atk_p = 1'b0;
      hit_p = 1'b0;
    end else begin
      atk_p = atk_ev;
      hit_p = hit_ev;
    end
    prev_a = a;
  endfunction

  task automatic check_model(int m, logic [3:0] s, logic [4:0] p, logic aa, logic bz);
    int ep;
    logic eaa, ebz;
    ep = frames_left(m);
    eaa = (cur[m] == 4'd4) || (cur[m] == 4'd7);
    ebz = (cur[m] >= 4'd3);
    n_chk++;
    if (s !== cur[m] || p !== 5'(ep) || aa !== eaa || bz !== ebz) begin
      n_fail++;
      $display("FAIL model[%0d] @%0t: got st=%0d ph=%0d aa=%0b busy=%0b, want st=%0d ph=%0d aa=%0b busy=%0b",
               m, $time, s, p, aa, bz, cur[m], ep, eaa, ebz);
    end
  endtask

  task automatic cycle(bit tk, bit l, bit r, bit a, bit h);
    @(negedge clk);
    frame_tick = tk;
    btn_left = l;
    btn_right = r;
    btn_attack = a;
    hit_in = h;
    model_step(tk, l, r, a, h);
    @(posedge clk);
    #1;
    check_model(0, st0, ph0, aa0, bz0);
    check_model(1, st1, ph1, aa1, bz1);
  endtask

  // One frame: an event cycle between ticks, then the tick itself.
  task automatic frame(bit l, bit r, bit a, bit h);
    cycle(1'b0, l, r, a, h);
    cycle(1'b1, l, r, 1'b0, 1'b0);
  endtask

  task automatic chk(string nm, logic [3:0] es, logic [4:0] ep);
    logic eaa, ebz;
    eaa = (es == 4'd4) || (es == 4'd7);
    ebz = (es >= 4'd3);
    n_chk++;
    if (st0 !== es || ph0 !== ep || aa0 !== eaa || bz0 !== ebz) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ph=%0d aa=%0b busy=%0b, want st=%0d ph=%0d aa=%0b busy=%0b",
               nm, st0, ph0, aa0, bz0, es, ep, eaa, ebz);
    end
  endtask

  task automatic chk1(string nm, logic [3:0] es);
    n_chk++;
    if (st1 !== es) begin
      n_fail++;
      $display("FAIL %s (mirrored): got st=%0d, want st=%0d", nm, st1, es);
    end
  endtask

  // Counts phase_cnt from 'from' down to 0 in state s, one frame each.
  task automatic run(string nm, logic [3:0] s, int from, bit l, bit r, bit press);
    for (int p = from; p >= 0; p--) begin
      frame(l, r, press && (p % 2 == 1), 1'b0);
      chk(nm, s, 5'(p));
    end
  endtask

  task automatic do_reset(string nm);
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0;
    btn_left = 1'b0;
    btn_right = 1'b0;
    btn_attack = 1'b0;
    hit_in = 1'b0;
    #1;
    chk(nm, 4'd0, 5'd0);
    chk1(nm, 4'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit l, r, a, h;
    logic [3:0] s0;
    logic [4:0] p0;
    logic [3:0] s1;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit l, bit r, bit a, bit h, logic [3:0] s0, logic [4:0] p0, logic [3:0] s1);
    vec_t v;
    v.l = l; v.r = r; v.a = a; v.h = h;
    v.s0 = s0; v.p0 = p0; v.s1 = s1;
    vecs.push_back(v);
  endfunction

  initial begin
    bit a_cur;
    // Idle, direction arbitration, plain attack with ignored re-presses.
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 4'd0, 5'd0, 4'd0);
    add(0, 1, 0, 0, 4'd2, 5'd0, 4'd1);
    add(1, 1, 0, 0, 4'd0, 5'd0, 4'd0);
    add(1, 0, 0, 0, 4'd1, 5'd0, 4'd2);
    add(0, 0, 0, 0, 4'd0, 5'd0, 4'd0);
    add(0, 0, 1, 0, 4'd3, 5'd3, 4'd3);
    add(0, 0, 0, 0, 4'd3, 5'd2, 4'd3);
    add(0, 0, 1, 0, 4'd3, 5'd1, 4'd3);
    add(0, 0, 0, 0, 4'd3, 5'd0, 4'd3);
    add(0, 0, 1, 0, 4'd4, 5'd1, 4'd4);
    add(0, 0, 0, 0, 4'd4, 5'd0, 4'd4);
    add(0, 0, 1, 0, 4'd5, 5'd7, 4'd5);
    for (int p = 6; p >= 0; p--) add(0, 0, (p % 2 == 1), 0, 4'd5, 5'(p), 4'd5);
    add(0, 0, 1, 0, 4'd0, 5'd0, 4'd0);
    add(0, 0, 0, 0, 4'd0, 5'd0, 4'd0);

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset", 4'd0, 5'd0);

    foreach (vecs[i]) begin
      frame(vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].h);
      chk($sformatf("vec%0d", i), vecs[i].s0, vecs[i].p0);
      chk1($sformatf("vec%0d", i), vecs[i].s1);
    end

    // Directional attack while holding forward; mirrored unit sees it as back.
    frame(0, 1, 1, 0);
    chk("dir_start", 4'd6, 5'd4);
    chk1("back_atk", 4'd3);
    run("dir_start", 4'd6, 3, 0, 1, 0);
    run("dir_active", 4'd7, 2, 0, 1, 0);
    run("dir_recov", 4'd8, 9, 0, 1, 0);
    frame(0, 1, 0, 0);
    chk("dir_end", 4'd0, 5'd0);
    frame(0, 1, 0, 0);
    chk("fwd_after", 4'd2, 5'd0);
    chk1("back_after", 4'd1);
    frame(1, 0, 1, 0);
    chk("back_atk", 4'd3, 5'd3);
    chk1("fwd_atk", 4'd6);
    run("atk_start", 4'd3, 2, 1, 0, 0);
    run("atk_active", 4'd4, 1, 1, 0, 0);
    run("atk_recov", 4'd5, 7, 1, 0, 0);
    frame(1, 0, 0, 0);
    chk("atk_end", 4'd0, 5'd0);

    // Block while holding back, then hit during active frames.
    frame(1, 0, 0, 0);
    chk("hold_back", 4'd1, 5'd0);
    frame(1, 0, 0, 1);
    chk("blockstun", 4'd10, 5'd5);
    run("blockstun", 4'd10, 4, 1, 0, 0);
    frame(0, 0, 0, 0);
    chk("block_end", 4'd0, 5'd0);
    frame(0, 0, 1, 0);
    chk("atk2", 4'd3, 5'd3);
    run("atk2_start", 4'd3, 2, 0, 0, 0);
    frame(0, 0, 0, 0);
    chk("atk2_active", 4'd4, 5'd1);
    frame(0, 0, 0, 1);
    chk("hit_active", 4'd9, 5'd11);
    frame(0, 0, 0, 0);
    chk("hitstun", 4'd9, 5'd10);
    frame(0, 0, 0, 1);
    chk("no_refresh", 4'd9, 5'd9);
    run("hitstun", 4'd9, 8, 0, 0, 0);
    frame(0, 0, 0, 0);
    chk("hit_end", 4'd0, 5'd0);

    // Hit and attack rise between the same ticks: hit wins, attack dropped.
    frame(0, 0, 1, 1);
    chk("hit_vs_atk", 4'd9, 5'd11);
    run("hitstun2", 4'd9, 10, 0, 0, 0);
    frame(0, 0, 0, 0);
    chk("hit2_end", 4'd0, 5'd0);
    frame(0, 0, 0, 0);
    chk("atk_dropped", 4'd0, 5'd0);

    // Async reset mid directional attack with events pending.
    frame(0, 1, 1, 0);
    chk("dir2", 4'd6, 5'd4);
    cycle(0, 0, 1, 1, 1);
    do_reset("async_rst");
    frame(0, 0, 0, 0);
    chk("no_pend_after_rst", 4'd0, 5'd0);

    // Random stimulus against the model.
    a_cur = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 777) do_reset("rand_rst");
      if ($urandom_range(0, 3) == 0) a_cur = ~a_cur;
      cycle($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom), a_cur,
            $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fighter_state_controller.md
Name: fighter_state_controller

Overview:
- Per-player frame-driven state machine that produces the 4-bit fighter state consumed by the sprite renderer, which uses it for movement and colour.
- Arbitrates movement, normal attack, directional attack, and incoming hit/block events.
- Sequences the timed attack and stun phases using a frame counter.
- One instance per player; IS_MIRRORED selects which button means "forward".

Parameters:
IS_MIRRORED, 0, 0 = player faces right (forward = btn_right); 1 = faces left (forward = btn_left)
ATK_START, 4, frames spent in S_Attack_start
ATK_ACTIVE, 2, frames spent in S_Attack_active
ATK_RECOV, 8, frames spent in S_Attack_recovery
DIR_START, 5, frames spent in S_DirAtk_start
DIR_ACTIVE, 3, frames spent in S_DirAtk_active
DIR_RECOV, 10, frames spent in S_DirAtk_recovery
HITSTUN, 12, frames spent in S_Hitstun
BLOCKSTUN, 6, frames spent in S_Blockstun
(All durations must be in the range 1..32.)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-clk pulse per video frame; all state changes happen only on this pulse
btn_left  input  1  level; player holds left
btn_right  input  1  level; player holds right
btn_attack  input  1  level; attack button
hit_in  input  1  one-clk pulse: opponent's active hitbox overlapped this player
state  output  4  0 IDLE, 1 Backward, 2 Forward, 3/4/5 Attack start/active/recovery, 6/7/8 DirAtk start/active/recovery, 9 Hitstun, 10 Blockstun
phase_cnt  output  5  frames remaining in the current timed state minus 1; 0 in free states
attack_active  output  1  high when state is 4 or 7
busy  output  1  high in any state other than 0, 1, 2

Behaviour:
- Reset (async assert, sync release): state=0, phase_cnt=0, attack_active=0, busy=0. All latches cleared.
- The previous value of btn_attack is registered for edge detection.
- atk_pend: set on any clk where btn_attack rises (0 to 1). Cleared on every frame_tick.
- hit_pend: set on any clk where hit_in=1. Cleared on every frame_tick.
- A set and a clear of the same latch in one cycle: the clear wins. An event arriving in the same clk as a tick is evaluated in that tick, as if already latched.
- fwd = btn_right when IS_MIRRORED=0, else btn_left. back = the other button.
- Outputs are registered and update exactly one clk after the tick. Nothing changes on clks without a tick.
- Priority on each frame_tick (highest first):
  1. hit_pend and state not 9/10: if state==1, go to Blockstun and load BLOCKSTUN-1; otherwise go to Hitstun and load HITSTUN-1. This interrupts any attack phase. A hit_pend while already in 9 or 10 is discarded; the stun is not refreshed.
  2. Timed state (3..10) with phase_cnt!=0: decrement phase_cnt.
  3. Timed state with phase_cnt==0, advance:
     - 3→4 (load ATK_ACTIVE-1), 4→5 (load ATK_RECOV-1), 5→0
     - 6→7 (load DIR_ACTIVE-1), 7→8 (load DIR_RECOV-1), 8→0
     - 9→0, 10→0
     - Entering 0 sets phase_cnt=0. Inputs are re-evaluated on the next tick, not this one.
  4. Free state (0/1/2) with atk_pend: if fwd&!back, go to 6 (load DIR_START-1); otherwise go to 3 (load ATK_START-1).
  5. Free state otherwise: fwd&!back→2, back&!fwd→1, both or neither→0.
- Attack presses made during states 3..10 are discarded at the next tick; there is no input buffering.
- Timed state X lasts exactly X_DURATION ticks. A duration of 1 advances on the very next tick.
- attack_active and busy are decoded from the next-state value and registered together with state, so they are always consistent with state.
- Reset mid-attack or mid-stun returns to IDLE immediately and drops any pending events.

Test Plan:
1. Reset with buttons idle, then 3 ticks → state=0, phase_cnt=0, busy=0 throughout.
2. IS_MIRRORED=0, hold btn_right, tick → state=2. Add btn_left, tick → state=0. Release btn_right, tick → state=1. Repeat with IS_MIRRORED=1 → states 1, 0, 2.
3. Pulse btn_attack between ticks with no direction held → 4 ticks in state 3, then 2 ticks in state 4 (attack_active=1), then 8 ticks in state 5, then state 0. Additional presses during this sequence cause no new attack.
4. Hold fwd and press attack → state=6 for 5 ticks, 7 for 3 ticks, 8 for 10 ticks, then 0. Holding back and pressing attack → state=3.
5. Pulse hit_in while in state 1 → next tick state=10, phase_cnt=5; idle after 6 ticks. Pulse hit_in during state 4 → state=9, phase_cnt=11. A second hit_in during 9 leaves phase_cnt still counting down.
6. hit_in and an attack rise between the same pair of ticks from state 0 → state=9 and the attack is dropped. Assert rst_n=0 mid-DirAtk → state=0 asynchronously, with no pending event surviving.
